ddr_refresh_sched: RTL and testbench

// - Post-init command scheduler. Shares the DDR4 command slot between the host read/write engine and auto-refresh.
// - Runs the tREFI interval timer and tracks postponed refreshes (max 8, JEDEC).
// - Sequences PREA -> tRP -> REF -> tRFC. Drives the *_rdy strobes into the command encoder.
// - Enabled once the init sequencer raises config_done.

---
 rtl/ddr_refresh_sched_pkg.sv | 22 ++
 rtl/ddr_ref_timer.sv | 49 ++++
 rtl/ddr_refresh_sched.sv | 124 ++++++++++++
 tb/tb_ddr_refresh_sched.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/ddr_refresh_sched_pkg.sv
// Shared DDR4 timing defaults (clock_t cycles at tCK 1.25ns) and the refresh scheduler state type.
// No logic; latency and backpressure do not apply.
package ddr_refresh_sched_pkg;

    localparam int T_MRD_CYC        = 8;
    localparam int T_MOD_CYC        = 24;
    localparam int T_ZQINIT_CYC     = 1024;
    localparam int T_REFI_CYC       = 6240;
    localparam int T_RFC_CYC        = 280;
    localparam int T_RP_CYC         = 11;
    localparam int MAX_POSTPONE_DEF = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_PREA,
        S_WAIT_RP,
        S_REF,
        S_WAIT_RFC
    } sched_state_t;

endpackage

// File: rtl/ddr_ref_timer.sv
// tREFI interval timer with a saturating postponed-refresh count and sticky miss flag.
// Latency: expiry/issue reflected in ref_pending one cycle later; no backpressure.
module ddr_ref_timer
    import ddr_refresh_sched_pkg::*;
#(
    parameter int T_REFI       = T_REFI_CYC,
    parameter int MAX_POSTPONE = MAX_POSTPONE_DEF,
    parameter int CNT_W        = 16
) (
    input  logic       clock_t,
    input  logic       reset,
    input  logic       en,
    input  logic       ref_issued,
    output logic [3:0] ref_pending,
    output logic       ref_miss_err
);

    localparam logic [CNT_W-1:0] REFI_LAST = CNT_W'(T_REFI - 1);
    localparam logic [3:0]       PEND_MAX  = 4'(MAX_POSTPONE);

    logic [CNT_W-1:0] interval_cnt;
    logic             expiry;

    assign expiry = en && (interval_cnt == REFI_LAST);

    always_ff @(posedge clock_t) begin
        if (reset) begin
            interval_cnt <= '0;
            ref_pending  <= '0;
            ref_miss_err <= 1'b0;
        end else if (!en) begin
            interval_cnt <= '0;
            ref_pending  <= '0;
        end else begin
            interval_cnt <= expiry ? '0 : interval_cnt + CNT_W'(1);
            // An expiry in the REF cycle cancels the decrement, so it can never overflow.
            if (expiry && !ref_issued) begin
                if (ref_pending == PEND_MAX) begin
                    ref_miss_err <= 1'b1;
                end else begin
                    ref_pending <= ref_pending + 4'd1;
                end
            end else if (!expiry && ref_issued && (ref_pending != 4'd0)) begin
                ref_pending <= ref_pending - 4'd1;
            end
        end
    end

endmodule

// File: rtl/ddr_refresh_sched.sv
// Arbitrates the DDR4 command slot between host R/W and auto-refresh (PREA -> tRP -> REF -> tRFC).
// Latency: grant one cycle after rw_req seen in IDLE; host holds the slot until rw_done (no preemption).
module ddr_refresh_sched
    import ddr_refresh_sched_pkg::*;
#(
    parameter int T_REFI       = T_REFI_CYC,
    parameter int T_RFC        = T_RFC_CYC,
    parameter int T_RP         = T_RP_CYC,
    parameter int MAX_POSTPONE = MAX_POSTPONE_DEF,
    parameter int CNT_W        = 16
) (
    input  logic       clock_t,
    input  logic       reset,
    input  logic       config_done,
    input  logic       rw_req,
    input  logic       rw_done,
    output logic       rw_gnt,
    output logic       prea_rdy,
    output logic       ref_rdy,
    output logic       des_rdy,
    output logic [3:0] ref_pending,
    output logic       ref_miss_err
);

    localparam logic [CNT_W-1:0] RP_LOAD  = CNT_W'(T_RP - 2);
    localparam logic [CNT_W-1:0] RFC_LOAD = CNT_W'(T_RFC - 2);
    localparam logic [3:0]       PEND_MAX = 4'(MAX_POSTPONE);

    sched_state_t     state, state_nxt;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic             ref_issued;

    assign ref_issued = (state == S_REF);

    ddr_ref_timer #(
        .T_REFI      (T_REFI),
        .MAX_POSTPONE(MAX_POSTPONE),
        .CNT_W       (CNT_W)
    ) u_ref_timer (
        .clock_t     (clock_t),
        .reset       (reset),
        .en          (config_done),
        .ref_issued  (ref_issued),
        .ref_pending (ref_pending),
        .ref_miss_err(ref_miss_err)
    );

    always_ff @(posedge clock_t) begin
        if (reset) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        rw_gnt       = 1'b0;
        prea_rdy     = 1'b0;
        ref_rdy      = 1'b0;
        des_rdy      = 1'b0;
        if (!config_done) begin
            state_nxt    = S_IDLE;
            wait_cnt_nxt = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    des_rdy = 1'b1;
                    // A saturated backlog outranks the host; otherwise the host wins.
                    if (ref_pending == PEND_MAX) begin
                        state_nxt = S_PREA;
                    end else if (rw_req) begin
                        state_nxt = S_GRANT;
                    end else if (ref_pending != 4'd0) begin
                        state_nxt = S_PREA;
                    end
                end
                S_GRANT: begin
                    rw_gnt = 1'b1;
                    if (rw_done) begin
                        state_nxt = S_IDLE;
                    end
                end
                S_PREA: begin
                    prea_rdy     = 1'b1;
                    state_nxt    = S_WAIT_RP;
                    wait_cnt_nxt = RP_LOAD;
                end
                S_WAIT_RP: begin
                    des_rdy = 1'b1;
                    if (wait_cnt == '0) begin
                        state_nxt = S_REF;
                    end else begin
                        wait_cnt_nxt = wait_cnt - CNT_W'(1);
                    end
                end
                S_REF: begin
                    ref_rdy      = 1'b1;
                    state_nxt    = S_WAIT_RFC;
                    wait_cnt_nxt = RFC_LOAD;
                end
                S_WAIT_RFC: begin
                    des_rdy = 1'b1;
                    if (wait_cnt == '0) begin
                        state_nxt = S_IDLE;
                    end else begin
                        wait_cnt_nxt = wait_cnt - CNT_W'(1);
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
        if (reset) begin
            rw_gnt   = 1'b0;
            prea_rdy = 1'b0;
            ref_rdy  = 1'b0;
            des_rdy  = 1'b0;
        end
    end

endmodule

// File: tb/tb_ddr_refresh_sched.sv
// Directed bench for ddr_refresh_sched with short sim timings (tREFI=100, tRFC=20, tRP=4).
// Cycle 0 is the cycle in which reset is released / config_done is raised.
module tb_ddr_refresh_sched;

    logic       clock_t     = 1'b0;
    logic       reset       = 1'b1;
    logic       config_done = 1'b0;
    logic       rw_req      = 1'b0;
    logic       rw_done     = 1'b0;
    logic       rw_gnt, prea_rdy, ref_rdy, des_rdy, ref_miss_err;
    logic [3:0] ref_pending;

    int n_cmp     = 0;
    int n_err     = 0;
    int cyc       = 0;
    int abs_cyc   = 0;
    int last_prea = -1000;
    int last_ref  = -1000;
    bit prev_gnt  = 1'b0;
    bit done_every10 = 1'b0;

    always #5 clock_t = ~clock_t;

    ddr_refresh_sched #(
        .T_REFI      (100),
        .T_RFC       (20),
        .T_RP        (4),
        .MAX_POSTPONE(8),
        .CNT_W       (16)
    ) dut (
        .clock_t     (clock_t),
        .reset       (reset),
        .config_done (config_done),
        .rw_req      (rw_req),
        .rw_done     (rw_done),
        .rw_gnt      (rw_gnt),
        .prea_rdy    (prea_rdy),
        .ref_rdy     (ref_rdy),
        .des_rdy     (des_rdy),
        .ref_pending (ref_pending),
        .ref_miss_err(ref_miss_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s at cycle %0d: observed %0h, expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Advance one clock; sample 1ns after the edge and run the per-cycle protocol checks.
    task automatic tick();
        @(posedge clock_t);
        #1;
        cyc++;
        abs_cyc++;
        if (config_done && !reset)
            chk("onehot", 32'($countones({rw_gnt, prea_rdy, ref_rdy, des_rdy})), 32'd1);
        else
            chk("quiet", {28'd0, rw_gnt, prea_rdy, ref_rdy, des_rdy}, 32'd0);
        chk("pend_le_max", 32'(ref_pending <= 4'd8), 32'd1);
        if (ref_rdy) begin
            chk("prea_to_ref", 32'(abs_cyc - last_prea), 32'd4);
            last_ref = abs_cyc;
        end
        if (prea_rdy || (rw_gnt && !prev_gnt))
            chk("ref_to_next_ge_trfc", 32'(abs_cyc - last_ref >= 20), 32'd1);
        if (prea_rdy)
            last_prea = abs_cyc;
        prev_gnt = rw_gnt;
        if (done_every10)
            rw_done = (cyc % 10 == 9);
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        rw_req       = 1'b0;
        rw_done      = 1'b0;
        done_every10 = 1'b0;
        tick();
        chk("rst_strobes", {28'd0, rw_gnt, prea_rdy, ref_rdy, des_rdy}, 32'd0);
        chk("rst_pending", 32'(ref_pending), 32'd0);
        chk("rst_miss_err", 32'(ref_miss_err), 32'd0);
        reset     = 1'b0;
        cyc       = 0;
        last_ref  = -1000;
        last_prea = -1000;
        prev_gnt  = 1'b0;
    endtask

    initial begin
        // Idle refresh
        do_reset();
        config_done = 1'b1;
        run_to(99);  chk("idle_pend99", 32'(ref_pending), 32'd0);
        run_to(100); chk("idle_pend100", 32'(ref_pending), 32'd1);
                     chk("idle_des100", 32'(des_rdy), 32'd1);
        run_to(101); chk("idle_prea101", 32'(prea_rdy), 32'd1);
        run_to(104); chk("idle_noref104", 32'(ref_rdy), 32'd0);
        run_to(105); chk("idle_ref105", 32'(ref_rdy), 32'd1);
                     chk("idle_pend105", 32'(ref_pending), 32'd1);
        run_to(106); chk("idle_pend106", 32'(ref_pending), 32'd0);
        run_to(124); rw_req = 1'b1;
        run_to(125); chk("idle_nogнt125", 32'(rw_gnt), 32'd0);
        run_to(126); chk("idle_gnt126", 32'(rw_gnt), 32'd1);
                     rw_req = 1'b0; rw_done = 1'b1;
        run_to(127); rw_done = 1'b0;
                     chk("idle_release127", 32'(rw_gnt), 32'd0);

        // Postpone until saturation, then forced refresh
        do_reset();
        rw_req = 1'b1; done_every10 = 1'b1;
        run_to(1);   chk("post_gnt1", 32'(rw_gnt), 32'd1);
        run_to(701); chk("post_gnt701", 32'(rw_gnt), 32'd1);
                     chk("post_pend701", 32'(ref_pending), 32'd7);
        run_to(800); chk("post_pend800", 32'(ref_pending), 32'd8);
                     chk("post_nognt800", 32'(rw_gnt), 32'd0);
        run_to(801); chk("post_prea801", 32'(prea_rdy), 32'd1);
        run_to(805); chk("post_ref805", 32'(ref_rdy), 32'd1);
        run_to(806); chk("post_pend806", 32'(ref_pending), 32'd7);
        run_to(825); chk("post_nognt825", 32'(rw_gnt), 32'd0);
        run_to(826); chk("post_gnt826", 32'(rw_gnt), 32'd1);
        run_to(830); chk("post_idle830", 32'(rw_gnt), 32'd0);
        run_to(831); chk("post_gnt831", 32'(rw_gnt), 32'd1);

        // Overflow: grant held with no release
        do_reset();
        rw_req = 1'b1;
        run_to(800); chk("ovf_pend800", 32'(ref_pending), 32'd8);
                     chk("ovf_gnt800", 32'(rw_gnt), 32'd1);
        run_to(899); chk("ovf_err899", 32'(ref_miss_err), 32'd0);
                     chk("ovf_pend899", 32'(ref_pending), 32'd8);
        run_to(900); chk("ovf_err900", 32'(ref_miss_err), 32'd1);
                     chk("ovf_pend900", 32'(ref_pending), 32'd8);
        run_to(950); rw_req = 1'b0; rw_done = 1'b1;
        run_to(951); rw_done = 1'b0;
                     chk("ovf_des951", 32'(des_rdy), 32'd1);
        run_to(952); chk("ovf_prea952", 32'(prea_rdy), 32'd1);
        run_to(956); chk("ovf_ref956", 32'(ref_rdy), 32'd1);
        run_to(957); chk("ovf_pend957", 32'(ref_pending), 32'd7);
                     chk("ovf_err957", 32'(ref_miss_err), 32'd1);
        config_done = 1'b0;
        run_to(958); chk("ovf_cfg_pend", 32'(ref_pending), 32'd0);
                     chk("ovf_cfg_err_sticky", 32'(ref_miss_err), 32'd1);

        // Expiry coinciding with the REF cycle, then config_done abort mid-tRFC
        do_reset();
        config_done = 1'b1;
        rw_req = 1'b1;
        run_to(200); chk("sim_pend200", 32'(ref_pending), 32'd2);
        run_to(293); rw_req = 1'b0; rw_done = 1'b1;
        run_to(294); rw_done = 1'b0;
        run_to(295); chk("sim_prea295", 32'(prea_rdy), 32'd1);
        run_to(299); chk("sim_ref299", 32'(ref_rdy), 32'd1);
                     chk("sim_pend299", 32'(ref_pending), 32'd2);
        run_to(300); chk("sim_pend300", 32'(ref_pending), 32'd2);
        run_to(305); chk("sim_des305", 32'(des_rdy), 32'd1);
        config_done = 1'b0;
        run_to(306); chk("abort_cfg_strobes", {28'd0, rw_gnt, prea_rdy, ref_rdy, des_rdy}, 32'd0);
                     chk("abort_cfg_pend", 32'(ref_pending), 32'd0);
        config_done = 1'b1;
        cyc = 0;
        run_to(100); chk("restart_noprea100", 32'(prea_rdy), 32'd0);
                     chk("restart_pend100", 32'(ref_pending), 32'd1);
        run_to(101); chk("restart_prea101", 32'(prea_rdy), 32'd1);

        // Reset abort mid-tRFC (do_reset checks outputs while reset is held)
        run_to(110); chk("abort_rst_des110", 32'(des_rdy), 32'd1);
        do_reset();
        run_to(100); chk("rst_restart_noprea100", 32'(prea_rdy), 32'd0);
        run_to(101); chk("rst_restart_prea101", 32'(prea_rdy), 32'd1);

        // Random host traffic; tick() checks exclusivity and command spacing
        for (int i = 0; i < 10000; i++) begin
            if (rw_gnt) begin
                rw_req  = 1'b0;
                rw_done = ($urandom_range(0, 15) == 0);
            end else begin
                rw_done = ($urandom_range(0, 31) == 0);
                if (!rw_req)
                    rw_req = ($urandom_range(0, 7) == 0);
            end
            tick();
        end
        chk("rand_no_miss", 32'(ref_miss_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
